cacheline_adaptor: RTL and testbench

Converts one 256-bit cacheline transaction from the memory arbiter into a four-beat, 64-bit burst on the physical memory port, and reassembles read bursts back into a line. Sits directly downstream of the arbiter, between its memory-side port and the burst DRAM model. The arbiter asserts a request for only one cycle and then waits for a response, so this block latches every request it accepts.

---
 rtl/mem_types_pkg.sv | 32 +++
 rtl/cacheline_adaptor.sv | 130 +++++++++++++
 tb/tb_cacheline_adaptor.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_types_pkg
//  Purpose  : Shared widths and types for the arbiter-to-memory path:
//             cacheline/burst geometry, the line container type and the
//             cacheline adaptor state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_types_pkg;

  localparam int LINE_W   = 256;
  localparam int BURST_W  = 64;
  localparam int BEATS    = 4;
  localparam int OFFSET_W = 5;
  localparam int ADDR_W   = 32;
  localparam int CNT_W    = 2;

  // Index of the final beat of a burst.
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } adaptor_state_e;

endpackage
`default_nettype wire

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module   : cacheline_adaptor
//  Purpose  : Turns one 256-bit line request from the arbiter into a
//             four-beat 64-bit burst to memory and reassembles read bursts
//             into a line. Requests are single-cycle pulses, so each accepted
//             request (address and write data) is latched.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             line_i/line_o   - write line in / assembled read line out
//             address_i       - byte address, sampled with read_i/write_i
//             read_i, write_i - line request pulses (write wins if both)
//             resp_o          - one-cycle completion pulse to the arbiter
//             burst_i/burst_o - read beat in / write beat out
//             address_o       - line-aligned address to memory
//             read_o, write_o - memory request, held for the whole burst
//             resp_i          - per-beat handshake from memory
//  Revision : 1.0 - initial release
// ============================================================================
module cacheline_adaptor
  import mem_types_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LINE_W-1:0]    line_i,
  output logic [LINE_W-1:0]    line_o,
  input  logic [ADDR_W-1:0]    address_i,
  input  logic                 read_i,
  input  logic                 write_i,
  output logic                 resp_o,
  input  logic [BURST_W-1:0]   burst_i,
  output logic [BURST_W-1:0]   burst_o,
  output logic [ADDR_W-1:0]    address_o,
  output logic                 read_o,
  output logic                 write_o,
  input  logic                 resp_i
);

  adaptor_state_e          state_q, state_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic [ADDR_W-1:0]       addr_q,  addr_d;
  line_t                   buf_q,   buf_d;    // write data, or read assembly
  line_t                   rline_q, rline_d;  // last completed read line

  logic [ADDR_W-1:0]       aligned_addr;
  logic [7:0]              beat_lsb;
  logic                    addr_offset_unused;

  assign aligned_addr       = {address_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign addr_offset_unused = ^address_i[OFFSET_W-1:0];
  assign beat_lsb           = {cnt_q, 6'b0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    rline_d = rline_q;

    case (state_q)
      ST_IDLE: begin
        if (write_i) begin
          buf_d   = line_i;
          addr_d  = aligned_addr;
          cnt_d   = '0;
          state_d = ST_WRITE;
        end else if (read_i) begin
          addr_d  = aligned_addr;
          cnt_d   = '0;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        if (resp_i) begin
          buf_d[beat_lsb +: BURST_W] = burst_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_BEAT) begin
            // Publish the whole line at once so line_o never shows a
            // partially assembled read.
            rline_d = {burst_i, buf_q[LINE_W-BURST_W-1:0]};
            state_d = ST_DONE;
          end
        end
      end

      ST_WRITE: begin
        if (resp_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      rline_q <= rline_d;
    end
  end

  // Every output is a register or a decode of the state register.
  assign read_o    = (state_q == ST_READ);
  assign write_o   = (state_q == ST_WRITE);
  assign resp_o    = (state_q == ST_DONE);
  assign address_o = addr_q;
  assign burst_o   = buf_q[beat_lsb +: BURST_W];
  assign line_o    = rline_q;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cacheline_adaptor
//  Purpose  : Self-checking bench for cacheline_adaptor. A memory model
//             answers bursts with configurable gaps; expected values come
//             from the line contents and the beat/gap arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int checks;
  int failures;

  // Last line the DUT should be presenting on line_o.
  logic [255:0] model_rline;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Runs one transaction. Cycle 0 is the request cycle; beat k is preceded
  // by gaps[k] idle cycles. Inputs change and outputs are sampled at negedge.
  // If inject > 0, read_i is pulsed in that cycle (mid-burst, must be ignored).
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [255:0] wline, input logic [255:0] mline,
                        input int g0, input int g1, input int g2, input int g3,
                        input int inject,
                        output logic hold_ok, output logic [255:0] bseen,
                        output int resp_cyc, output int resp_cnt,
                        output logic [255:0] lout);
    int   gaps[4];
    int   cyc;
    logic exp_wr;
    gaps[0] = g0; gaps[1] = g1; gaps[2] = g2; gaps[3] = g3;
    exp_wr   = wr;
    hold_ok  = 1'b1;
    bseen    = '0;
    resp_cyc = -1;
    resp_cnt = 0;
    lout     = '0;
    @(negedge clk);
    cyc       = 0;
    read_i    = rd;
    write_i   = wr;
    address_i = addr;
    line_i    = wline;
    resp_i    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g <= gaps[k]; g++) begin
        @(negedge clk);
        cyc++;
        read_i  = (cyc == inject);
        write_i = 1'b0;
        line_i  = rand_line();
        address_i = $urandom;
        if (exp_wr ? (write_o !== 1'b1 || read_o !== 1'b0)
                   : (read_o !== 1'b1 || write_o !== 1'b0)) hold_ok = 1'b0;
        if (address_o !== {addr[31:5], 5'b0}) hold_ok = 1'b0;
        if (resp_o !== 1'b0) begin
          resp_cnt++;
          if (resp_cyc < 0) resp_cyc = cyc;
        end
        if (g == gaps[k]) begin
          resp_i  = 1'b1;
          burst_i = mline[64*k +: 64];
          bseen[64*k +: 64] = burst_o;
        end else begin
          resp_i  = 1'b0;
          burst_i = {$urandom, $urandom};
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      cyc++;
      resp_i  = 1'b0;
      read_i  = 1'b0;
      if (j == 0) lout = line_o;
      if (read_o !== 1'b0 || write_o !== 1'b0) hold_ok = 1'b0;
      if (resp_o === 1'b1) begin
        resp_cnt++;
        if (resp_cyc < 0) resp_cyc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got read_o=%b write_o=%b resp_o=%b, want 0 0 0", read_o, write_o, resp_o);
    end
    checks++;
    if (address_o !== 32'h0 || burst_o !== 64'h0 || line_o !== 256'h0) begin
      failures++;
      $display("FAIL reset_data: got address_o=%h burst_o=%h line_o=%h, want all zero", address_o, burst_o, line_o);
    end
    rst = 1'b0;
    model_rline = '0;
  endtask

  task automatic test_read_b2b();
    logic [255:0] mline, bseen, lout;
    logic hold_ok;
    int rc, rn;
    mline = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_txn(1'b1, 1'b0, 32'h0000_1234, rand_line(), mline, 0, 0, 0, 0, 0,
           hold_ok, bseen, rc, rn, lout);
    model_rline = mline;
    checks++;
    if (hold_ok !== 1'b1) begin
      failures++;
      $display("FAIL read_b2b_hold: read_o/address_o(0x00001220) not held, got ok=%b want 1", hold_ok);
    end
    checks++;
    if (rc != 5 || rn != 1) begin
      failures++;
      $display("FAIL read_b2b_resp: got resp cycle=%0d count=%0d, want 5 and 1", rc, rn);
    end
    checks++;
    if (lout !== mline) begin
      failures++;
      $display("FAIL read_b2b_line: got %h want %h", lout, mline);
    end
  endtask

  task automatic test_write_gaps();
    logic [255:0] wline, bseen, lout;
    logic hold_ok;
    int rc, rn;
    wline = {64'hD, 64'hC, 64'hB, 64'hA};
    do_txn(1'b0, 1'b1, 32'hABCD_0047, wline, rand_line(), 1, 2, 0, 2, 0,
           hold_ok, bseen, rc, rn, lout);
    checks++;
    if (bseen !== wline) begin
      failures++;
      $display("FAIL write_gaps_beats: got %h want %h", bseen, wline);
    end
    checks++;
    if (hold_ok !== 1'b1) begin
      failures++;
      $display("FAIL write_gaps_hold: write_o not held cycles 1-9, got ok=%b want 1", hold_ok);
    end
    checks++;
    if (rc != 10 || rn != 1) begin
      failures++;
      $display("FAIL write_gaps_resp: got resp cycle=%0d count=%0d, want 10 and 1", rc, rn);
    end
    checks++;
    if (lout !== model_rline) begin
      failures++;
      $display("FAIL write_gaps_line_hold: got %h want %h", lout, model_rline);
    end
  endtask

  task automatic test_simultaneous();
    logic [255:0] wline, bseen, lout;
    logic hold_ok;
    int rc, rn;
    wline = rand_line();
    do_txn(1'b1, 1'b1, 32'h0000_8000, wline, rand_line(), 0, 1, 0, 0, 0,
           hold_ok, bseen, rc, rn, lout);
    checks++;
    if (hold_ok !== 1'b1 || bseen !== wline) begin
      failures++;
      $display("FAIL simul_write_wins: got ok=%b beats=%h, want ok=1 beats=%h", hold_ok, bseen, wline);
    end
    checks++;
    if (rc != 6 || rn != 1 || lout !== model_rline) begin
      failures++;
      $display("FAIL simul_resp: got cycle=%0d count=%0d line=%h, want 6 1 %h", rc, rn, lout, model_rline);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [255:0] mline, bseen, lout;
    logic hold_ok;
    int rc, rn, stray;
    mline = rand_line();
    @(negedge clk);
    read_i = 1'b1; address_i = 32'h0000_4444;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      read_i  = 1'b0;
      resp_i  = 1'b1;
      burst_i = mline[64*k +: 64];
    end
    @(negedge clk);
    resp_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (read_o !== 1'b0 || resp_o !== 1'b0 || address_o !== 32'h0 || burst_o !== 64'h0 || line_o !== 256'h0) begin
      failures++;
      $display("FAIL reset_mid_read_outputs: got read_o=%b resp_o=%b addr=%h burst=%h line=%h, want all zero",
               read_o, resp_o, address_o, burst_o, line_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_rline = '0;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_o !== 1'b0 || read_o !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL reset_mid_read_quiet: got %0d active cycles, want 0", stray);
    end
    mline = rand_line();
    do_txn(1'b1, 1'b0, 32'h0000_4460, rand_line(), mline, 0, 0, 0, 0, 0,
           hold_ok, bseen, rc, rn, lout);
    model_rline = mline;
    checks++;
    if (hold_ok !== 1'b1 || rc != 5 || rn != 1 || lout !== mline) begin
      failures++;
      $display("FAIL reset_mid_read_fresh: got ok=%b cycle=%0d count=%0d line=%h, want 1 5 1 %h",
               hold_ok, rc, rn, lout, mline);
    end
  endtask

  task automatic test_stray_and_ignored();
    logic [255:0] mline, wline, bseen, lout;
    logic hold_ok;
    int rc, rn, active;
    active = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      resp_i  = (i != 2);
      burst_i = {$urandom, $urandom};
      if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) active++;
    end
    @(negedge clk);
    resp_i = 1'b0;
    if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) active++;
    checks++;
    if (active != 0) begin
      failures++;
      $display("FAIL stray_resp_idle: got %0d active cycles, want 0", active);
    end
    // A stray beat must not have advanced the counter: a clean read follows.
    mline = rand_line();
    do_txn(1'b1, 1'b0, 32'h1000_0000, rand_line(), mline, 0, 0, 0, 0, 0,
           hold_ok, bseen, rc, rn, lout);
    model_rline = mline;
    checks++;
    if (rc != 5 || rn != 1 || lout !== mline) begin
      failures++;
      $display("FAIL stray_then_read: got cycle=%0d count=%0d line=%h, want 5 1 %h", rc, rn, lout, mline);
    end
    wline = rand_line();
    do_txn(1'b0, 1'b1, 32'h2000_0020, wline, rand_line(), 0, 1, 1, 0, 2,
           hold_ok, bseen, rc, rn, lout);
    checks++;
    if (hold_ok !== 1'b1 || bseen !== wline || rc != 7 || rn != 1) begin
      failures++;
      $display("FAIL ignored_read_in_write: got ok=%b cycle=%0d count=%0d, want 1 7 1", hold_ok, rc, rn);
    end
  endtask

  task automatic test_line_hold();
    logic [255:0] x, y, bseen, lout;
    logic hold_ok;
    int rc, rn;
    x = rand_line();
    y = rand_line();
    do_txn(1'b1, 1'b0, 32'h0300_0040, rand_line(), x, 1, 0, 2, 0, 0,
           hold_ok, bseen, rc, rn, lout);
    model_rline = x;
    do_txn(1'b0, 1'b1, 32'h0300_0080, y, rand_line(), 0, 0, 0, 0, 0,
           hold_ok, bseen, rc, rn, lout);
    checks++;
    if (lout !== x || line_o !== x) begin
      failures++;
      $display("FAIL line_hold: got %h want %h", line_o, x);
    end
  endtask

  task automatic test_random();
    logic [255:0] wline, mline, bseen, lout;
    logic hold_ok;
    logic rd, wr;
    int rc, rn, g0, g1, g2, g3, kind, bad;
    bad = 0;
    for (int n = 0; n < 24; n++) begin
      kind  = $urandom_range(0, 2);
      rd    = (kind != 1);
      wr    = (kind != 0);
      wline = rand_line();
      mline = rand_line();
      g0 = $urandom_range(0, 3); g1 = $urandom_range(0, 3);
      g2 = $urandom_range(0, 3); g3 = $urandom_range(0, 3);
      do_txn(rd, wr, $urandom, wline, mline, g0, g1, g2, g3, 0,
             hold_ok, bseen, rc, rn, lout);
      if (!wr) model_rline = mline;
      checks++;
      if (hold_ok !== 1'b1 || rc != 5 + g0 + g1 + g2 + g3 || rn != 1 ||
          lout !== model_rline || (wr && bseen !== wline)) begin
        failures++;
        bad++;
        if (bad <= 4)
          $display("FAIL random_txn%0d: got ok=%b cycle=%0d count=%0d line=%h, want 1 %0d 1 %h",
                   n, hold_ok, rc, rn, lout, 5 + g0 + g1 + g2 + g3, model_rline);
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    model_rline = '0;

    test_reset();
    test_read_b2b();
    test_write_gaps();
    test_simultaneous();
    test_reset_mid_read();
    test_stray_and_ignored();
    test_line_hold();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
